bus_wr_rd_master: RTL

Self-checking bus master that sits directly upstream of the 8-bit memory-style DUT on the shared read/write bus. On a start pulse it writes a deterministic pattern to a block of addresses, reads the same block back, compares each returned byte against the expected value, and reports pass/fail, error count and the first failing address. It replaces hand-written write/read stimulus and gives the bench a single-pulse, repeatable traffic source.

---
 rtl/bus_test_pkg.sv | 21 ++
 rtl/rd_cmp_pipe.sv | 62 ++++++
 rtl/bus_wr_rd_master.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bus_test_pkg.sv
// Shared types and helpers for the self-checking write/read bus master.
package bus_test_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, DONE} state_t;

  // One issued read as seen by the compare pipeline.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmp_req_t;

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seed,
                                                input logic [7:0]        i);
    return seed + i;
  endfunction

endpackage

// File: rtl/rd_cmp_pipe.sv
// Expected-data delay line matched to read latency, plus mismatch counting
// and first-failing-address capture.
module rd_cmp_pipe
  import bus_test_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  cmp_req_t          req,
  input  logic [DATA_W-1:0] rdata,
  output logic [7:0]        err_cnt,
  output logic [7:0]        err_nxt,
  output logic [ADDR_W-1:0] first_err_addr
);

  // req comes from registered bus outputs, so RD_LAT stages line the
  // expected byte up with the cycle the memory presents rdata.
  localparam int STAGES = RD_LAT - 1;

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][ADDR_W-1:0] addr_pipe;
  logic [STAGES:0][DATA_W-1:0] data_pipe;
  logic                        mismatch;

  // Case inequality so an undriven or X read shows up as an error.
  assign mismatch = vld_pipe[STAGES] && (rdata !== data_pipe[STAGES]);

  always_comb begin
    err_nxt = err_cnt;
    if (clr)
      err_nxt = '0;
    else if (mismatch && (err_cnt != 8'hFF))
      err_nxt = err_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe       <= '0;
      addr_pipe      <= '0;
      data_pipe      <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      vld_pipe[0]  <= req.vld;
      addr_pipe[0] <= req.addr;
      data_pipe[0] <= req.data;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
        data_pipe[k] <= data_pipe[k-1];
      end
      err_cnt <= err_nxt;
      if (clr)
        first_err_addr <= '0;
      else if (mismatch && (err_cnt == 8'd0))
        first_err_addr <= addr_pipe[STAGES];
    end
  end

endmodule

// File: rtl/bus_wr_rd_master.sv
// Single-pulse write-then-readback traffic source with built-in data check.
module bus_wr_rd_master
  import bus_test_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              enable,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata
);

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [7:0]        beat_q, beat_d, nxt, last;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [1:0]        drain_q, drain_d;
  logic              en_d, wr_d, rd_d, done_d, pass_d, clr;
  logic [ADDR_W-1:0] waddr_d, raddr_d;
  logic [DATA_W-1:0] wdata_d, exp_q, exp_d;
  logic [7:0]        err_nxt;
  cmp_req_t          req;

  assign nxt  = beat_q + 8'd1;
  // count==0 wraps to 255 here, giving the full 256-location block.
  assign last = cnt_q - 8'd1;
  assign busy = (state_q != IDLE);

  // Outputs are computed one cycle ahead and registered, so every bus
  // signal comes straight from a flop.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    drain_d = drain_q;
    en_d    = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    waddr_d = waddr;
    wdata_d = wdata;
    raddr_d = raddr;
    exp_d   = exp_q;
    done_d  = 1'b0;
    pass_d  = pass;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        base_d  = base_addr;
        cnt_d   = count;
        seed_d  = seed;
        clr     = 1'b1;
        pass_d  = 1'b0;
        beat_d  = '0;
        state_d = WRITE;
        en_d    = 1'b1;
        wr_d    = 1'b1;
        waddr_d = base_addr;
        wdata_d = seed;
      end
      WRITE: if (beat_q == last) begin
        state_d = GAP;
      end else begin
        beat_d  = nxt;
        en_d    = 1'b1;
        wr_d    = 1'b1;
        waddr_d = base_q + nxt;
        wdata_d = pattern(seed_q, nxt);
      end
      GAP: begin
        state_d = READ;
        beat_d  = '0;
        en_d    = 1'b1;
        rd_d    = 1'b1;
        raddr_d = base_q;
        exp_d   = pattern(seed_q, 8'd0);
      end
      READ: if (beat_q == last) begin
        state_d = DRAIN;
        drain_d = '0;
      end else begin
        beat_d  = nxt;
        en_d    = 1'b1;
        rd_d    = 1'b1;
        raddr_d = base_q + nxt;
        exp_d   = pattern(seed_q, nxt);
      end
      // The last compare lands on the same edge that enters DONE, so
      // pass is taken from the counter's next value.
      DRAIN: if (drain_q == DRAIN_LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (err_nxt == 8'd0);
      end else begin
        drain_d = drain_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      seed_q  <= '0;
      drain_q <= '0;
      enable  <= 1'b0;
      write   <= 1'b0;
      read    <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      raddr   <= '0;
      exp_q   <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      drain_q <= drain_d;
      enable  <= en_d;
      write   <= wr_d;
      read    <= rd_d;
      waddr   <= waddr_d;
      wdata   <= wdata_d;
      raddr   <= raddr_d;
      exp_q   <= exp_d;
      done    <= done_d;
      pass    <= pass_d;
    end
  end

  assign req.vld  = read;
  assign req.addr = raddr;
  assign req.data = exp_q;

  rd_cmp_pipe #(.RD_LAT(RD_LAT)) u_cmp (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (clr),
    .req            (req),
    .rdata          (rdata),
    .err_cnt        (err_cnt),
    .err_nxt        (err_nxt),
    .first_err_addr (first_err_addr)
  );

endmodule
